// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer whose interrupt feeds cp0 HWInt[2].
// Software writes PRESET and CTRL with sw and reads COUNT with lw.
// When the count reaches zero the timer raises an interrupt, either once
// (one-shot) or repeatedly (auto-reload, Mode == 1).
//
// Ports
//   clk    rising-edge clock
//   reset  synchronous, active-high
//   Addr   word select (bus addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT, 3 reserved
//   WE     write strobe for the word selected by Addr
//   DIn    write data
//   DOut   read data, combinational from Addr
//   IRQ    CTRL.IM & irq_pending
//
// CTRL[3:0] = {IM, Mode[1:0], Enable}
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | stopped; waits for Enable
// ST_LOAD | copies PRESET into COUNT
// ST_CNT  | decrements COUNT; at 1 (or 0) sets irq_pending
// ST_INT  | terminal count reached; reload (Mode 1) or stop (one-shot)
module timer_dev #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] PRESET_RST = '0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] DIn,
  output logic [31:0] DOut,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CNT,
    ST_INT
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q;
  logic [3:0]       ctrl_q;
  logic [WIDTH-1:0] preset_q;
  logic [WIDTH-1:0] count_q;
  logic             irq_pending_q;

  logic ctrl_we;
  logic preset_we;
  logic enable;
  logic mode_reload;

  assign ctrl_we     = WE && (Addr == 2'd0);
  assign preset_we   = WE && (Addr == 2'd1);
  assign enable      = ctrl_q[0];
  assign mode_reload = (ctrl_q[2:1] == 2'b01);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      ctrl_q        <= 4'b0;
      preset_q      <= PRESET_RST;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      if (preset_we) begin
        preset_q <= DIn[WIDTH-1:0];
      end

      // A CTRL write restarts the controller and drops any pending event,
      // taking priority over whatever the FSM would have done this cycle.
      if (ctrl_we) begin
        ctrl_q        <= DIn[3:0];
        state_q       <= ST_IDLE;
        irq_pending_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (enable) state_q <= ST_LOAD;
          end
          ST_LOAD: begin
            count_q <= preset_q;
            state_q <= ST_CNT;
          end
          ST_CNT: begin
            if (!enable) begin
              state_q <= ST_IDLE;
            end else if (count_q > ONE) begin
              count_q <= count_q - ONE;
            end else begin
              // Saturate at zero so PRESET=0 behaves like PRESET=1.
              count_q       <= '0;
              irq_pending_q <= 1'b1;
              state_q       <= ST_INT;
            end
          end
          ST_INT: begin
            if (mode_reload) begin
              irq_pending_q <= 1'b0;
              state_q       <= ST_LOAD;
            end else begin
              // One-shot: pending is left set until software rewrites CTRL.
              ctrl_q[0] <= 1'b0;
              state_q   <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    DOut = 32'b0;
    case (Addr)
      2'd0:    DOut = {28'b0, ctrl_q};
      2'd1:    DOut = 32'(preset_q);
      2'd2:    DOut = 32'(count_q);
      default: DOut = 32'b0;
    endcase
  end

  assign IRQ = ctrl_q[3] & irq_pending_q;

endmodule

// File: tb/tb_timer_dev.sv
module tb_timer_dev;

  logic        clk;
  logic        reset;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;
  logic        IRQ;

  int n_chk  = 0;
  int n_fail = 0;

  timer_dev #(.WIDTH(32), .PRESET_RST(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .DIn   (DIn),
    .DOut  (DOut),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [31:0] din;
    logic [1:0]  ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    WE = 1'b1; Addr = a; DIn = d;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    Addr = a;
    #1;
    d = DOut;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Reference: a run begins when CTRL is written (edge 0). COUNT holds its
  // old value for two edges, then walks P, P-1, ... down to 0 over L=max(P,1)
  // cycles; the zero cycle carries the interrupt. Auto-reload repeats that
  // pattern every L+2 cycles; one-shot clears Enable one cycle after zero.
  function automatic void ref_state(input int k, input logic [31:0] p,
                                    input logic [3:0] c, input logic [31:0] base,
                                    output logic [31:0] cnt, output logic [3:0] ctl,
                                    output logic irq);
    longint lp, j, m;
    cnt = base; ctl = c; irq = 1'b0;
    if (c[0] && k >= 2) begin
      j  = longint'(k - 2);
      lp = (p == 0) ? 1 : longint'(p);
      if (c[2:1] == 2'b01) begin
        m   = j % (lp + 2);
        cnt = (m < lp) ? p - 32'(m) : 32'd0;
        irq = c[3] && (m == lp);
      end else if (j < lp) begin
        cnt = p - 32'(j);
      end else begin
        cnt = 32'd0;
        irq = c[3];
        if (j > lp) ctl = c & 4'b1110;
      end
    end
  endfunction

  int          cyc = 0;
  int          m_t0;
  logic [31:0] m_preset, m_p, m_base, m_cnt_last;
  logic [3:0]  m_ctrl;
  bit          force_ctrl = 0;

  task automatic rstep();
    int          r;
    logic [31:0] d;
    logic [1:0]  a;
    logic        w;
    logic [31:0] e_cnt, got;
    logic [3:0]  e_ctl;
    logic        e_irq;
    r = $urandom_range(0, 99);
    d = $urandom;
    w = 1'b1;
    a = 2'd0;
    if (force_ctrl || (r >= 12 && r < 22)) begin
      a = 2'd0;
      d[0] = ($urandom_range(0, 9) < 7);
      force_ctrl = 0;
    end else if (r < 12) begin
      a = 2'd1;
      d = $urandom_range(0, 9);
      force_ctrl = 1;
    end else if (r < 27) begin
      a = 2'($urandom_range(2, 3));
    end else begin
      w = 1'b0;
      a = 2'($urandom_range(0, 3));
    end
    WE = w; Addr = a; DIn = d;
    @(posedge clk);
    cyc++;
    if (w && a == 2'd1) m_preset = d;
    if (w && a == 2'd0) begin
      m_base = m_cnt_last;
      m_t0   = cyc;
      m_p    = m_preset;
      m_ctrl = d[3:0];
    end
    ref_state(cyc - m_t0, m_p, m_ctrl, m_base, e_cnt, e_ctl, e_irq);
    m_cnt_last = e_cnt;
    #1;
    WE = 1'b0;
    chk("rnd_irq", {31'b0, IRQ}, {31'b0, e_irq});
    rd(2'd2, got); chk("rnd_count", got, e_cnt);
    rd(2'd0, got); chk("rnd_ctrl", got, {28'b0, e_ctl});
    rd(2'd1, got); chk("rnd_preset", got, m_preset);
  endtask

  initial begin
    logic [31:0] v;

    vecs[0]  = '{1'b0, 2'd0, 32'h0,         2'd0, 32'h0};
    vecs[1]  = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h0};
    vecs[2]  = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h0};
    vecs[3]  = '{1'b0, 2'd0, 32'h0,         2'd3, 32'h0};
    vecs[4]  = '{1'b1, 2'd1, 32'h1234_5678, 2'd1, 32'h1234_5678};
    vecs[5]  = '{1'b1, 2'd0, 32'hFFFF_FFF4, 2'd0, 32'h4};
    vecs[6]  = '{1'b1, 2'd2, 32'h0000_DEAD, 2'd2, 32'h0};
    vecs[7]  = '{1'b1, 2'd3, 32'h0000_BEEF, 2'd3, 32'h0};
    vecs[8]  = '{1'b1, 2'd3, 32'h0000_BEEF, 2'd1, 32'h1234_5678};
    vecs[9]  = '{1'b1, 2'd0, 32'hFFFF_FFF5, 2'd0, 32'h5};
    vecs[10] = '{1'b1, 2'd2, 32'h0,         2'd0, 32'h5};
    vecs[11] = '{1'b0, 2'd0, 32'h0,         2'd2, 32'h1234_5678};
    vecs[12] = '{1'b1, 2'd1, 32'h7,         2'd2, 32'h1234_5677};
    vecs[13] = '{1'b0, 2'd0, 32'h0,         2'd1, 32'h7};

    reset = 1'b1; WE = 1'b0; Addr = 2'd0; DIn = 32'h0;
    do_reset();
    chk("reset_irq", {31'b0, IRQ}, 32'h0);

    // Register access table
    for (int i = 0; i < 14; i++) begin
      WE = vecs[i].we; Addr = vecs[i].wa; DIn = vecs[i].din;
      @(posedge clk);
      #1;
      WE = 1'b0;
      rd(vecs[i].ra, v);
      chk($sformatf("vec%0d", i), v, vecs[i].exp);
    end

    // One-shot, PRESET=3, IM=1
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 8; k++) begin
      tick();
      rd(2'd2, v);
      if (k >= 2) chk($sformatf("os_count_t%0d", k), v, (k <= 5) ? 32'(5 - k) : 32'd0);
      chk($sformatf("os_irq_t%0d", k), {31'b0, IRQ}, (k >= 5) ? 32'd1 : 32'd0);
      if (k >= 6) begin
        rd(2'd0, v);
        chk($sformatf("os_ctrl_t%0d", k), v, 32'h8);
      end
    end

    // Clearing a pending one-shot event with a CTRL write
    wr(2'd0, 32'h0);
    chk("clr_irq", {31'b0, IRQ}, 32'h0);
    chk("clr_pending", {31'b0, dut.irq_pending_q}, 32'h0);
    tick(); tick();
    rd(2'd2, v);
    chk("clr_count", v, 32'h0);

    // Auto-reload, PRESET=2: pulses every 4 cycles
    wr(2'd1, 32'd2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 14; k++) begin
      tick();
      chk($sformatf("ar_irq_t%0d", k), {31'b0, IRQ}, (k % 4 == 0) ? 32'd1 : 32'd0);
      rd(2'd2, v);
      if (k == 2 || k == 6) chk($sformatf("ar_count_t%0d", k), v, 32'd2);
      if (k == 3 || k == 7) chk($sformatf("ar_count_t%0d", k), v, 32'd1);
      if (k == 4 || k == 5) chk($sformatf("ar_count_t%0d", k), v, 32'd0);
    end

    // Disable mid-count freezes COUNT; re-enabling reloads PRESET
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 6; k++) tick();
    rd(2'd2, v);
    chk("frz_before", v, 32'd6);
    wr(2'd0, 32'h8);
    for (int k = 0; k < 5; k++) begin
      tick();
      rd(2'd2, v);
      chk("frz_count", v, 32'd6);
      chk("frz_irq", {31'b0, IRQ}, 32'h0);
    end
    wr(2'd0, 32'h9);
    tick(); tick();
    rd(2'd2, v);
    chk("frz_reload", v, 32'd10);

    // CTRL write on the cycle the count would reach zero wins
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h9);
    for (int k = 1; k <= 4; k++) tick();
    wr(2'd0, 32'h9);
    chk("race_irq", {31'b0, IRQ}, 32'h0);
    chk("race_pending", {31'b0, dut.irq_pending_q}, 32'h0);
    rd(2'd2, v);
    chk("race_count", v, 32'd1);

    // Masked interrupt: pending rises, IRQ stays low
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("mask_irq", {31'b0, IRQ}, 32'h0);
      if (k >= 3) chk("mask_pending", {31'b0, dut.irq_pending_q}, 32'h1);
    end

    // Reset in the middle of counting
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    tick(); tick(); tick();
    rd(2'd2, v);
    chk("mid_count", v, 32'd4);
    reset = 1'b1;
    tick();
    rd(2'd0, v); chk("mid_rst_ctrl", v, 32'h0);
    rd(2'd1, v); chk("mid_rst_preset", v, 32'h0);
    rd(2'd2, v); chk("mid_rst_count", v, 32'h0);
    chk("mid_rst_irq", {31'b0, IRQ}, 32'h0);
    chk("mid_rst_pending", {31'b0, dut.irq_pending_q}, 32'h0);
    reset = 1'b0;

    // Randomized traffic against the reference
    do_reset();
    m_preset = 32'h0; m_p = 32'h0; m_base = 32'h0; m_cnt_last = 32'h0;
    m_ctrl = 4'h0; m_t0 = cyc;
    for (int i = 0; i < 1500; i++) rstep();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
